// File: rtl/gcd_dispatch.sv
// gcd_dispatch: request front-end for the gcd engine.
//
// Operand pairs arrive on a valid/ready input, wait in a small FIFO, and are
// issued one at a time to the engine with a single-cycle start pulse. The
// result is presented, with its operands echoed, on a valid/ready output.
// A watchdog turns a hung engine into an error result (out_err=1,
// out_result=0) so the pipeline keeps moving.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid/in_ready       request handshake, operands in_a/in_b
//   eng_a/eng_b/eng_start   operands and start pulse to the engine
//   eng_done/eng_result     engine completion and result
//   out_valid/out_ready     result handshake
//   out_result/out_a/out_b  gcd (0 on error) and echoed operands
//   out_err                 result produced by watchdog timeout
//   fifo_count              current FIFO occupancy
module gcd_dispatch #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic [WIDTH-1:0]         eng_a,
    output logic [WIDTH-1:0]         eng_b,
    output logic                     eng_start,
    input  logic                     eng_done,
    input  logic [WIDTH-1:0]         eng_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [WIDTH-1:0]         out_a,
    output logic [WIDTH-1:0]         out_b,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned WdW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic [WdW-1:0]   wd_q;
    logic [WIDTH-1:0] eng_a_q, eng_b_q;
    logic [WIDTH-1:0] out_result_q, out_a_q, out_b_q;
    logic             out_err_q;

    logic push, pop, timed_out;

    // Full is decoded from the registered count only, so a pop in the same
    // cycle never frees a slot for a push.
    assign in_ready   = (count_q != CntW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = (state_q == StIssue);
    assign timed_out  = (wd_q == WdW'(TIMEOUT - 1));
    assign fifo_count = count_q;

    assign eng_start  = (state_q == StIssue);
    assign out_valid  = (state_q == StHold);
    assign eng_a      = eng_a_q;
    assign eng_b      = eng_b_q;
    assign out_result = out_result_q;
    assign out_a      = out_a_q;
    assign out_b      = out_b_q;
    assign out_err    = out_err_q;

    // Storage needs no reset: an entry is only read once count says it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q] <= in_a;
            mem_b[wr_ptr_q] <= in_b;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (count_q != '0) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (eng_done || timed_out) state_d = StHold;
            StHold:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wd_q         <= '0;
            eng_a_q      <= '0;
            eng_b_q      <= '0;
            out_result_q <= '0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase

            // Head is loaded on the way into ISSUE so it is valid with the start pulse.
            if (state_q == StIdle && count_q != '0) begin
                eng_a_q <= mem_a[rd_ptr_q];
                eng_b_q <= mem_b[rd_ptr_q];
            end

            if (state_q == StIssue) begin
                wd_q <= '0;
            end else if (state_q == StWait) begin
                wd_q <= wd_q + WdW'(1);
            end

            // Done wins over a timeout landing in the same cycle.
            if (state_q == StWait && (eng_done || timed_out)) begin
                out_result_q <= eng_done ? eng_result : '0;
                out_err_q    <= !eng_done;
                out_a_q      <= eng_a_q;
                out_b_q      <= eng_b_q;
            end
        end
    end

endmodule

// File: tb/tb_gcd_dispatch.sv
module tb_gcd_dispatch;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CntW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_a, in_b, eng_a, eng_b, eng_result;
    logic             eng_start, eng_done;
    logic             out_valid, out_ready, out_err;
    logic [WIDTH-1:0] out_result, out_a, out_b;
    logic [CntW-1:0]  fifo_count;

    always #5 clk = ~clk;

    gcd_dispatch #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_err    (out_err),
        .fifo_count (fifo_count)
    );

    // lat: WAIT cycle in which the engine model raises done; above TIMEOUT = hung.
    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int unsigned      lat;
        int               t_push;
        bit               chk;
    } req_t;

    req_t stim_q[$];
    req_t fifo_q[$];
    req_t res_q[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          eng_busy = 0;
    int unsigned eng_cnt = 0;
    req_t        eng_cur;
    bit          spurious_en = 0;
    bit          rand_rdy = 0;
    int          gap_pct = 0;
    int          hold_left = 0;
    int          hold_seen = 0;
    int          full_seen = 0;
    bit          out_seen = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x = a;
        logic [WIDTH-1:0] y = b;
        logic [WIDTH-1:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic req_t mk(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input int unsigned lat, input bit chk);
        req_t r;
        r.a = a;
        r.b = b;
        r.lat = lat;
        r.t_push = 0;
        r.chk = chk;
        return r;
    endfunction

    // One clock of the reference: check what the DUT shows at the negedge, then
    // drive the inputs for the next rising edge.
    task automatic cycle();
        req_t        r;
        bit          room;
        bit          err;
        int unsigned lat_eff;
        @(negedge clk);
        cyc++;
        room = (fifo_q.size() != DEPTH);
        check("in_ready", in_ready, room);
        check("fifo_count", fifo_count, fifo_q.size());
        if (!room) full_seen++;

        if (out_valid && hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
            hold_seen++;
        end else begin
            out_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        end

        if (out_valid) begin
            check("start_in_hold", eng_start, 0);
            eng_busy = 0;
            if (res_q.size() == 0) begin
                check("unexpected_out_valid", out_valid, 0);
            end else begin
                r = res_q[0];
                err = (r.lat > TIMEOUT);
                lat_eff = err ? TIMEOUT : r.lat;
                check("out_result", out_result, err ? '0 : ref_gcd(r.a, r.b));
                check("out_a", out_a, r.a);
                check("out_b", out_b, r.b);
                check("out_err", out_err, err);
                if (r.chk && !out_seen) check("out_latency", cyc - r.t_push, 3 + lat_eff);
                out_seen = 1;
                if (out_ready) begin
                    void'(res_q.pop_front());
                    out_seen = 0;
                end
            end
        end

        if (eng_start) begin
            if (fifo_q.size() == 0) begin
                check("unexpected_start", eng_start, 0);
            end else begin
                r = fifo_q.pop_front();
                check("eng_a", eng_a, r.a);
                check("eng_b", eng_b, r.b);
                if (r.chk) check("start_latency", cyc - r.t_push, 2);
                res_q.push_back(r);
                eng_busy = 1;
                eng_cnt = 0;
                eng_cur = r;
            end
        end

        eng_done = 1'b0;
        eng_result = $urandom;
        if (eng_busy && !eng_start) begin
            eng_cnt++;
            if (eng_cnt == eng_cur.lat) begin
                eng_done = 1'b1;
                eng_result = ref_gcd(eng_cur.a, eng_cur.b);
                eng_busy = 0;
            end
        end else if (!eng_busy && spurious_en && $urandom_range(0, 4) == 0) begin
            eng_done = 1'b1;
        end

        in_valid = 1'b0;
        if (stim_q.size() != 0 && $urandom_range(0, 99) >= gap_pct) begin
            in_valid = 1'b1;
            in_a = stim_q[0].a;
            in_b = stim_q[0].b;
            if (room) begin
                r = stim_q.pop_front();
                r.t_push = cyc;
                fifo_q.push_back(r);
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((stim_q.size() + fifo_q.size() + res_q.size()) != 0 && n < budget) begin
            cycle();
            n++;
        end
        check("drain_done", stim_q.size() + fifo_q.size() + res_q.size(), 0);
        repeat (3) cycle();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_result"}, out_result, 0);
        check({tag, "_out_a"}, out_a, 0);
        check({tag, "_out_b"}, out_b, 0);
        check({tag, "_out_err"}, out_err, 0);
        check({tag, "_eng_start"}, eng_start, 0);
        check({tag, "_eng_a"}, eng_a, 0);
        check({tag, "_eng_b"}, eng_b, 0);
        check({tag, "_fifo_count"}, fifo_count, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        int n;
        logic [WIDTH-1:0] g;
        in_valid = 0;
        in_a = '0;
        in_b = '0;
        eng_done = 0;
        eng_result = '0;
        out_ready = 0;
        reset_n = 0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        reset_n = 1;

        // Single request with known latency.
        stim_q.push_back(mk(48, 18, 7, 1));
        drain(200);

        // Stalled engine, six back-to-back pushes; first lands on done/timeout coincidence.
        full_seen = 0;
        stim_q.push_back(mk(1001, 143, TIMEOUT, 1));
        for (int i = 0; i < 5; i++) begin
            stim_q.push_back(mk($urandom_range(1, 5000), $urandom_range(1, 5000),
                                $urandom_range(2, 8), 0));
        end
        drain(400);
        check("fifo_full_seen", full_seen > 0, 1);

        // Consumer stalls ten cycles with a second request waiting.
        hold_left = 10;
        hold_seen = 0;
        stim_q.push_back(mk(35, 14, 3, 1));
        stim_q.push_back(mk(21, 49, 2, 0));
        drain(200);
        check("hold_cycles", hold_seen, 10);

        // Hung engine times out, next request runs normally; spurious dones from here on.
        spurious_en = 1;
        stim_q.push_back(mk(1000, 10, 100, 1));
        stim_q.push_back(mk(100, 75, 5, 0));
        drain(200);
        stim_q.push_back(mk(91, 65, TIMEOUT, 1));
        stim_q.push_back(mk(0, 12, 1, 0));
        drain(200);

        // Reset while in WAIT with two entries queued.
        for (int i = 0; i < 3; i++) stim_q.push_back(mk(60 + i, 24, 100, 0));
        n = 0;
        while (!(eng_busy && fifo_q.size() == 2 && eng_cnt >= 2) && n < 30) begin
            cycle();
            n++;
        end
        check("reached_wait", eng_busy && fifo_q.size() == 2, 1);
        @(negedge clk);
        reset_n = 0;
        in_valid = 0;
        eng_done = 0;
        stim_q.delete();
        fifo_q.delete();
        res_q.delete();
        eng_busy = 0;
        out_seen = 0;
        hold_left = 0;
        #1;
        check_cleared("midreset");
        @(negedge clk);
        reset_n = 1;
        repeat (20) cycle();

        // Randomised traffic.
        rand_rdy = 1;
        gap_pct = 30;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                stim_q.push_back(mk($urandom, $urandom, $urandom_range(1, TIMEOUT + 4), 0));
            end else begin
                g = $urandom_range(1, 500);
                stim_q.push_back(mk(g * $urandom_range(0, 300), g * $urandom_range(0, 300),
                                    $urandom_range(1, TIMEOUT + 4), 0));
            end
        end
        drain(5000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gcd_dispatch.md
Name: gcd_dispatch

Overview:
- Request front-end for the gcd engine.
- Accepts operand pairs over a valid/ready interface and buffers them in a small FIFO.
- Issues each pair to the engine with a one-cycle start pulse, waits for done, and presents the result, with its operands echoed, on a valid/ready output.
- Adds a watchdog so a hung engine cannot stall the pipeline forever.

Parameters:
- WIDTH, 32: operand and result width.
- DEPTH, 4: input FIFO entries; power of 2, minimum 2.
- TIMEOUT, 1024: maximum cycles in WAIT before an error result is produced; minimum 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  FIFO can accept a request.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- eng_a  out  WIDTH  operand a to engine.
- eng_b  out  WIDTH  operand b to engine.
- eng_start  out  1  one-cycle start pulse to engine.
- eng_done  in  1  engine result valid.
- eng_result  in  WIDTH  engine result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  GCD; 0 on error.
- out_a  out  WIDTH  echoed operand a.
- out_b  out  WIDTH  echoed operand b.
- out_err  out  1  timeout flag for this result.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, active-low): FIFO empty, pointers and count 0, state IDLE, watchdog 0. All outputs 0 except in_ready=1.
- FIFO:
  - Push on rising edge when in_valid && in_ready.
  - in_ready = (count != DEPTH), decoded from registered count only. No push is accepted when full, even if a pop occurs in the same cycle.
  - Pop occurs only in the ISSUE state.
  - Pointers wrap modulo DEPTH.
  - A simultaneous push and pop leaves the count unchanged.
- FSM states:
  - IDLE: if count != 0, go to ISSUE next edge; else stay.
  - ISSUE (1 cycle):
    - eng_start=1.
    - eng_a/eng_b registers take the FIFO head values on entry to ISSUE, i.e. they are valid during the start cycle.
    - Pop the head.
    - Clear the watchdog.
    - Go to WAIT.
  - WAIT:
    - eng_a/eng_b held stable.
    - Watchdog increments each cycle.
    - If eng_done=1: capture eng_result into out_result, eng_a/eng_b into out_a/out_b, out_err=0, go to HOLD.
    - Else if watchdog == TIMEOUT-1: out_result=0, out_a/out_b captured, out_err=1, go to HOLD.
    - eng_done has priority over timeout in the same cycle.
  - HOLD:
    - out_valid=1.
    - out_result, out_a, out_b and out_err are held stable until out_ready.
    - On out_valid && out_ready: go to IDLE, out_valid drops next cycle.
- Output registers retain their last value after out_valid drops.
- eng_done is ignored in IDLE, ISSUE and HOLD. Only the first done seen in WAIT is consumed.
- eng_start is exactly one cycle wide per request and is never asserted outside ISSUE.
- Latency, empty FIFO, IDLE, push at edge E0:
  - State is ISSUE after E1; eng_start is high between E1 and E2.
  - State is WAIT after E2.
  - If done is high in cycle k of WAIT, out_valid is high from the following edge.
  - Minimum request-to-out_valid latency is 4 edges including 1 done cycle. Throughput is at most 1 result per 4 cycles.
- Operands are passed through unmodified: no swap or zero checks; the engine handles zeros.
- Requests complete strictly in FIFO order.
- Asserting reset_n low mid-operation discards the FIFO contents and any in-flight request. No output or start pulse occurs afterwards until a new push.

Test Plan:
- Single request (in_a=48, in_b=18); engine model asserts done after 7 cycles with result 6 -> eng_start high exactly 1 cycle with eng_a=48, eng_b=18. Then out_valid=1, out_result=6, out_a=48, out_b=18, out_err=0. Accepted on out_ready=1.
- Engine model stalled, DEPTH=4; push 6 pairs back-to-back -> first pair issued, next 4 buffered, fifo_count=4, in_ready=0 on 6th. Releasing the engine drains all results in push order; the 6th is then accepted.
- out_ready held 0 for 10 cycles after a result (a=35, b=14, result=7) -> out_valid and out_result=7 stable throughout. No eng_start during HOLD even with the FIFO non-empty.
- TIMEOUT=16, engine never asserts done -> after 16 WAIT cycles out_valid=1, out_err=1, out_result=0. The next request then issues normally.
- Spurious eng_done pulses in IDLE and HOLD; done and timeout coincide in WAIT -> spurious pulses ignored. The coincident case yields engine result with out_err=0.
- reset_n driven low during WAIT with 2 entries queued -> outputs 0, fifo_count=0, in_ready=1. No eng_start after reset release until a new push.
